alu_arbiter_ctrl: RTL

Sequencer and two-port arbiter that shares one alu_with_flags instance (4-bit, 3-bit opcode, carry/zero/overflow flags) between two requesters. It accepts one command at a time over a valid/ready handshake and registers the operands. It drives the ALU from those registers, captures the result and flags, and returns them on a single response channel tagged with the requester ID. Round-robin fairness applies when both requesters are active.

---
 rtl/alu_arbiter_ctrl_pkg.sv | 22 ++
 rtl/alu_with_flags.sv | 53 +++++
 rtl/alu_arbiter_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_arbiter_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sequencer: opcodes, FSM states, widths.
package alu_arbiter_ctrl_pkg;

  localparam int unsigned ALU_W = 4;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_with_flags.sv
// 4-bit combinational ALU with carry/zero/overflow; SUB reports borrow on carry.
module alu_with_flags
  import alu_arbiter_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned MSB = ALU_W - 1;

  logic [ALU_W:0] sum;

  always_comb begin
    sum      = '0;
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = sum[ALU_W-1:0];
        carry    = sum[ALU_W];
        overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sum      = {1'b0, a} - {1'b0, b};
        result   = sum[ALU_W-1:0];
        carry    = sum[ALU_W];
        overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[ALU_W-2:0], 1'b0};
        carry  = a[MSB];
      end
      OP_SHR: begin
        result = {1'b0, a[ALU_W-1:1]};
        carry  = a[0];
      end
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one alu_with_flags between two requesters.
module alu_arbiter_ctrl
  import alu_arbiter_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_carry,
  output logic              resp_zero,
  output logic              resp_overflow,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_e            state, state_nxt;
  logic              rr_ptr;
  logic              grant;
  logic              accept;
  logic              resp_fire;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              id_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_zero, alu_overflow;

  // ALU only ever sees the latched command, never the requester ports
  alu_with_flags u_alu (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (alu_result),
    .carry    (alu_carry),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    accept     = 1'b0;
    resp_fire  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        grant = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = !grant;
          req1_ready = grant;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (resp_valid && resp_ready) begin
          resp_fire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      rr_ptr        <= 1'b0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_result   <= '0;
      resp_carry    <= 1'b0;
      resp_zero     <= 1'b0;
      resp_overflow <= 1'b0;
      op_count      <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (accept) begin
        op_q <= grant ? req1_op : req0_op;
        a_q  <= grant ? req1_a  : req0_a;
        b_q  <= grant ? req1_b  : req0_b;
        id_q <= grant;
      end
      if (state == EXEC) begin
        resp_valid    <= 1'b1;
        resp_id       <= id_q;
        resp_result   <= alu_result;
        resp_carry    <= alu_carry;
        resp_zero     <= alu_zero;
        resp_overflow <= alu_overflow;
      end
      // the requester just served loses priority on the next contention
      if (resp_fire) begin
        resp_valid <= 1'b0;
        op_count   <= op_count + CNT_W'(1);
        rr_ptr     <= ~resp_id;
      end
    end
  end

endmodule
